// File: rtl/cdc_pkg.sv
// Shared types and constants for the req/ack clock-domain-crossing controllers.
package cdc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ_H = 2'd1,
        REQ_L = 2'd2
    } hs_state_t;

    localparam int DEF_SYNC_STAGES = 2;

    // Width of a phase timer that must be able to hold the value t.
    function automatic int tmo_width(input int t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit multi-flop synchroniser; last stage is the usable output.
module cdc_sync_bit
    import cdc_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign sync_d[gi] = d_i;
            end else begin : g_rest
                assign sync_d[gi] = sync_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_hs_tx_ctrl.sv
// Source-side 4-phase req/ack controller: holds a word on data_o while a
// single-bit request crosses to the destination and the ack returns.
module cdc_hs_tx_ctrl
    import cdc_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int TIMEOUT     = 255,
    parameter int CNT_W       = 16
) (
    input  logic              clkA,
    input  logic              rstA,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [DATA_W-1:0] data_o,
    output logic              req_o,
    input  logic              ack_i,
    output logic              done_o,
    output logic              busy_o,
    output logic              err_o,
    input  logic              clr_err,
    output logic [CNT_W-1:0]  xfer_cnt
);

    localparam int              TMO_W   = tmo_width(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

    hs_state_t         state_q, state_d;
    logic              req_q, req_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              tmo_hit;
    logic              ack_s;
    logic              accept;

    cdc_sync_bit #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clk_i(clkA),
        .rst_i(rstA),
        .d_i  (ack_i),
        .q_o  (ack_s)
    );

    // A lingering ack in IDLE blocks acceptance until the far side lets go.
    assign accept = (state_q == IDLE) && !ack_s && in_valid;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = REQ_H;
                    req_d   = 1'b1;
                    data_d  = in_data;
                end
            end
            REQ_H: begin
                if (ack_s) begin
                    state_d = REQ_L;
                    req_d   = 1'b0;
                end
            end
            REQ_L: begin
                if (!ack_s) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // Phase timer restarts on every state change and saturates at TIMEOUT;
    // only the step onto TIMEOUT raises the error, so a later clear sticks.
    always_comb begin
        tmo_d   = '0;
        tmo_hit = 1'b0;
        if ((TIMEOUT != 0) && (state_q != IDLE) && (state_d == state_q)) begin
            if (tmo_q != TMO_MAX) begin
                tmo_d   = tmo_q + 1'b1;
                tmo_hit = (tmo_d == TMO_MAX);
            end else begin
                tmo_d = tmo_q;
            end
        end
    end

    assign err_d = tmo_hit | (err_q & ~clr_err);

    always_ff @(posedge clkA or posedge rstA) begin
        if (rstA) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    assign in_ready = (state_q == IDLE) && !ack_s;
    assign busy_o   = (state_q != IDLE);
    assign data_o   = data_q;
    assign req_o    = req_q;
    assign done_o   = done_q;
    assign err_o    = err_q;
    assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_cdc_hs_tx_ctrl.sv
// Bench for cdc_hs_tx_ctrl: clkB-side ack BFM, upstream driver and a
// scoreboard of accepted words checked against each completed handshake.
module tb_cdc_hs_tx_ctrl;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic              clkA = 1'b0;
    logic              rstA;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [DATA_W-1:0] data_o;
    logic              req_o;
    logic              ack_i;
    logic              done_o;
    logic              busy_o;
    logic              err_o;
    logic              clr_err;
    logic [CNT_W-1:0]  xfer_cnt;

    cdc_hs_tx_ctrl #(
        .DATA_W     (DATA_W),
        .SYNC_STAGES(2),
        .TIMEOUT    (10),
        .CNT_W      (CNT_W)
    ) dut (
        .clkA    (clkA),
        .rstA    (rstA),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_ready(in_ready),
        .data_o  (data_o),
        .req_o   (req_o),
        .ack_i   (ack_i),
        .done_o  (done_o),
        .busy_o  (busy_o),
        .err_o   (err_o),
        .clr_err (clr_err),
        .xfer_cnt(xfer_cnt)
    );

    always #5 clkA = ~clkA;

    // clkB-side responder: mirrors req onto ack after bfm_dly cycles.
    logic bfm_ack;
    logic stale_ack;
    bit   bfm_en;
    int   bfm_dly;
    int   bfm_cnt;

    always @(negedge clkA or posedge rstA) begin
        if (rstA) begin
            bfm_ack <= 1'b0;
            bfm_cnt <= 0;
        end else if (!bfm_en || (req_o == bfm_ack)) begin
            bfm_cnt <= 0;
        end else if (bfm_cnt + 1 >= bfm_dly) begin
            bfm_ack <= req_o;
            bfm_cnt <= 0;
        end else begin
            bfm_cnt <= bfm_cnt + 1;
        end
    end

    assign ack_i = bfm_ack | stale_ack;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                ack_dly;
        logic [CNT_W-1:0]  exp_cnt;
    } vec_t;

    vec_t              vecs[4];
    logic [DATA_W-1:0] tx_q[$];
    logic [DATA_W-1:0] exp_q[$];
    logic [CNT_W-1:0]  exp_cnt;
    logic [DATA_W-1:0] held;
    logic              prev_req;
    logic              prev_busy;
    int                done_cnt;
    int                n_checks;
    int                n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive_in();
        in_valid = (tx_q.size() != 0);
        in_data  = (tx_q.size() != 0) ? tx_q[0] : '0;
    endtask

    task automatic send(input logic [DATA_W-1:0] d);
        tx_q.push_back(d);
        drive_in();
    endtask

    // One clkA cycle: sample at the falling edge, then run scoreboard checks.
    task automatic tick();
        bit acc;
        acc = in_valid && in_ready && !rstA;
        @(negedge clkA);
        if (acc) begin
            exp_q.push_back(tx_q.pop_front());
            check("req_lat", req_o, 1'b1);
            check("ready_busy", in_ready, 1'b0);
        end
        if (busy_o && prev_busy) check("data_hold", data_o, held);
        if (req_o && !prev_req) held = data_o;
        if (done_o) begin
            done_cnt++;
            exp_cnt = exp_cnt + 1'b1;
            check("xfer_cnt", xfer_cnt, exp_cnt);
            check("ready_at_done", in_ready, 1'b1);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL done_spurious: got done_o=1, expected no pending word at %0t", $time);
            end else begin
                check("xfer_data", held, exp_q.pop_front());
            end
        end
        prev_req  = req_o;
        prev_busy = busy_o;
        drive_in();
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check({name, "_done"}, done_cnt, target);
    endtask

    task automatic clear_model();
        tx_q.delete();
        exp_q.delete();
        exp_cnt   = '0;
        held      = '0;
        prev_req  = 1'b0;
        prev_busy = 1'b0;
        drive_in();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected end before %0t", $time);
        $fatal(1);
    end

    initial begin
        int base;
        n_checks  = 0;
        n_fail    = 0;
        done_cnt  = 0;
        rstA      = 1'b1;
        clr_err   = 1'b0;
        stale_ack = 1'b0;
        bfm_en    = 1'b1;
        bfm_dly   = 3;
        clear_model();

        vecs[0] = '{data: 8'hA5, ack_dly: 3, exp_cnt: 4'd1};
        vecs[1] = '{data: 8'h5A, ack_dly: 1, exp_cnt: 4'd2};
        vecs[2] = '{data: 8'hFF, ack_dly: 5, exp_cnt: 4'd3};
        vecs[3] = '{data: 8'h00, ack_dly: 2, exp_cnt: 4'd4};

        repeat (2) @(negedge clkA);
        check("rst_req", req_o, 1'b0);
        check("rst_data", data_o, 8'h00);
        check("rst_ready", in_ready, 1'b1);
        check("rst_done", done_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_cnt", xfer_cnt, 4'd0);
        rstA = 1'b0;
        tick();

        // Table-driven single transfers with varying ack latency.
        for (int i = 0; i < 4; i++) begin
            bfm_dly = vecs[i].ack_dly;
            base    = done_cnt;
            send(vecs[i].data);
            wait_done(base + 1, 100, "vec");
            repeat (3) tick();
            check("vec_one_done", done_cnt, base + 1);
            check("vec_cnt", xfer_cnt, vecs[i].exp_cnt);
            check("vec_data", data_o, vecs[i].data);
        end

        // Back-to-back with in_valid held across transfers.
        bfm_dly = 2;
        base    = done_cnt;
        send(8'h01);
        send(8'h02);
        send(8'h03);
        wait_done(base + 3, 300, "b2b");
        check("b2b_cnt", xfer_cnt, 4'd7);

        // Timeout: no ack, error at the 10th edge in REQ_H, set beats clear.
        bfm_en = 0;
        send(8'hC3);
        tick();
        check("tmo_req_up", req_o, 1'b1);
        repeat (9) tick();
        check("tmo_err_early", err_o, 1'b0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("tmo_set_wins", err_o, 1'b1);
        check("tmo_req_held", req_o, 1'b1);
        tick();
        check("tmo_sticky", err_o, 1'b1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("tmo_clr", err_o, 1'b0);
        repeat (3) tick();
        check("tmo_stay_clr", err_o, 1'b0);
        check("tmo_no_abort", busy_o, 1'b1);
        base   = done_cnt;
        bfm_en = 1;
        wait_done(base + 1, 100, "tmo");
        check("tmo_cnt", xfer_cnt, 4'd8);

        // Stale ack while idle blocks acceptance until it clears.
        bfm_en    = 0;
        stale_ack = 1'b1;
        repeat (3) tick();
        check("stale_ready", in_ready, 1'b0);
        send(8'h3C);
        repeat (4) tick();
        check("stale_no_cap", busy_o, 1'b0);
        check("stale_data", data_o, 8'hC3);
        base      = done_cnt;
        stale_ack = 1'b0;
        bfm_en    = 1;
        wait_done(base + 1, 100, "stale");
        check("stale_cnt", xfer_cnt, 4'd9);

        // Asynchronous reset mid-transfer with err_o set.
        bfm_en = 0;
        send(8'h77);
        repeat (12) tick();
        check("prerst_err", err_o, 1'b1);
        check("prerst_req", req_o, 1'b1);
        #2 rstA = 1'b1;
        #1;
        check("arst_req", req_o, 1'b0);
        check("arst_ready", in_ready, 1'b1);
        check("arst_cnt", xfer_cnt, 4'd0);
        check("arst_err", err_o, 1'b0);
        check("arst_busy", busy_o, 1'b0);
        check("arst_data", data_o, 8'h00);
        clear_model();
        @(negedge clkA);
        rstA = 1'b0;

        // Counter wrap: 16 transfers bring a 4-bit count back to zero.
        bfm_en  = 1;
        bfm_dly = 1;
        base    = done_cnt;
        for (int i = 0; i < 16; i++) send(DATA_W'($urandom_range(255)));
        wait_done(base + 16, 1000, "wrap");
        repeat (3) tick();
        check("wrap_pulses", done_cnt - base, 16);
        check("wrap_cnt", xfer_cnt, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
